// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage and data memory.
// The stage is the master; the memory (or its model) is the slave.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// RISC-V memory-access stage: byte-lane loads/stores over a req/ack bus, stall while busy, writeback register.
// Optional misaligned-access trap enabled by defining MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        EN,
    input  logic [31:0] DR,
    input  logic [4:0]  DR_num,
    input  logic [31:0] WriteData,
    input  logic [31:0] PC_plus_4,
    input  logic [1:0]  ResultSrc,
    input  logic        RegWrite,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    output logic [31:0] ALUResData,
    output logic        stall,
    mem_stage_if.master dmem,
    output logic [31:0] W_ALURes,
    output logic [31:0] W_ReadData,
    output logic [31:0] W_PC_plus_4,
    output logic [4:0]  W_DR_num,
    output logic [1:0]  W_ResultSrc,
    output logic        W_RegWrite,
    output logic        misalign_trap,
    output logic [31:0] misalign_addr
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state, state_next;
    logic        mis;
    logic        access;
    logic [1:0]  lane;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;

    assign ALUResData = DR;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign mis = (MemRead | MemWrite) &
                 (((funct3[1:0] == 2'b01) & DR[0]) | (funct3[1] & (DR[1:0] != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    assign access        = EN & (MemRead | MemWrite) & ~mis;
    // Reset gates the request combinationally so an in-flight access drops at once.
    assign dmem.dmem_req = ~reset & (((state == S_IDLE) & access) | (state == S_WAIT));
    assign stall         = dmem.dmem_req & ~dmem.dmem_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (dmem.dmem_req & ~dmem.dmem_ack) state_next = S_WAIT;
            S_WAIT: if (dmem.dmem_ack)                  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Lane offset ignores address bits below the access size.
    always_comb begin
        lane = 2'b00;
        case (funct3[1:0])
            2'b00:   lane = DR[1:0];
            2'b01:   lane = {DR[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

    assign dmem.dmem_addr = {DR[31:2], 2'b00};
    assign dmem.dmem_we   = MemWrite;

    always_comb begin
        dmem.dmem_be    = 4'b1111;
        dmem.dmem_wdata = WriteData;
        if (MemWrite) begin
            case (funct3[1:0])
                2'b00: begin
                    dmem.dmem_be    = 4'b0001 << lane;
                    dmem.dmem_wdata = {4{WriteData[7:0]}};
                end
                2'b01: begin
                    dmem.dmem_be    = 4'b0011 << lane;
                    dmem.dmem_wdata = {2{WriteData[15:0]}};
                end
                default: begin
                    dmem.dmem_be    = 4'b1111;
                    dmem.dmem_wdata = WriteData;
                end
            endcase
        end
    end

    assign rdata_shifted = dmem.dmem_rdata >> {lane, 3'b000};

    always_comb begin
        load_data = dmem.dmem_rdata;
        case (funct3)
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
            default: load_data = dmem.dmem_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            W_ALURes    <= 32'd0;
            W_ReadData  <= 32'd0;
            W_PC_plus_4 <= 32'd0;
            W_DR_num    <= 5'd0;
            W_ResultSrc <= 2'd0;
            W_RegWrite  <= 1'b0;
        end else if (stall) begin
            W_RegWrite <= 1'b0;
        end else if (EN) begin
            W_ALURes    <= DR;
            W_ReadData  <= (MemRead & ~MemWrite) ? load_data : 32'd0;
            W_PC_plus_4 <= PC_plus_4;
            W_DR_num    <= DR_num;
            W_ResultSrc <= ResultSrc;
            W_RegWrite  <= RegWrite & ~mis;
        end
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    // Trap is a single-cycle pulse; the faulting address is held until the next trap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_trap <= 1'b0;
            misalign_addr <= 32'd0;
        end else if (~stall & EN & mis) begin
            misalign_trap <= 1'b1;
            misalign_addr <= DR;
        end else begin
            misalign_trap <= 1'b0;
        end
    end
`else
    assign misalign_trap = 1'b0;
    assign misalign_addr = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; the bench itself plays the data memory.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        EN;
    logic [31:0] DR;
    logic [4:0]  DR_num;
    logic [31:0] WriteData;
    logic [31:0] PC_plus_4;
    logic [1:0]  ResultSrc;
    logic        RegWrite, MemWrite, MemRead;
    logic [2:0]  funct3;
    logic [31:0] ALUResData;
    logic        stall;
    logic [31:0] W_ALURes, W_ReadData, W_PC_plus_4;
    logic [4:0]  W_DR_num;
    logic [1:0]  W_ResultSrc;
    logic        W_RegWrite;
    logic        misalign_trap;
    logic [31:0] misalign_addr;

    int errors = 0;
    int checks = 0;
    int stall_cycles;

    mem_stage_if dmem ();

    mem_stage dut (
        .clk(clk), .reset(reset), .EN(EN), .DR(DR), .DR_num(DR_num),
        .WriteData(WriteData), .PC_plus_4(PC_plus_4), .ResultSrc(ResultSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead), .funct3(funct3),
        .ALUResData(ALUResData), .stall(stall), .dmem(dmem.master),
        .W_ALURes(W_ALURes), .W_ReadData(W_ReadData), .W_PC_plus_4(W_PC_plus_4),
        .W_DR_num(W_DR_num), .W_ResultSrc(W_ResultSrc), .W_RegWrite(W_RegWrite),
        .misalign_trap(misalign_trap), .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [31:0] dr, input logic [31:0] wd,
                         input logic [2:0] f3, input logic rd, input logic wr,
                         input logic rw, input logic [4:0] num);
        EN = en; DR = dr; WriteData = wd; funct3 = f3;
        MemRead = rd; MemWrite = wr; RegWrite = rw; DR_num = num;
        PC_plus_4 = dr + 32'd4; ResultSrc = rd ? 2'd1 : 2'd0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 32'd0;
        repeat (2) tick();
        check("rst_req", {31'd0, dmem.dmem_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_walu", W_ALURes, 32'd0);
        check("rst_wrw", {31'd0, W_RegWrite}, 32'd0);
        reset = 1'b0;
        tick();

        // SW, zero-wait ack
        drive(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0);
        dmem.dmem_ack = 1'b1;
        #1;
        check("sw_req", {31'd0, dmem.dmem_req}, 32'd1);
        check("sw_we", {31'd0, dmem.dmem_we}, 32'd1);
        check("sw_addr", dmem.dmem_addr, 32'h100);
        check("sw_be", {28'd0, dmem.dmem_be}, 32'hF);
        check("sw_wdata", dmem.dmem_wdata, 32'hDEADBEEF);
        check("sw_stall", {31'd0, stall}, 32'd0);
        tick();
        check("sw_wrw", {31'd0, W_RegWrite}, 32'd0);
        check("sw_walu", W_ALURes, 32'h100);
        dmem.dmem_ack = 1'b0;

        // ADD with EN low for two cycles, then captured
        drive(1'b0, 32'h42, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd7);
        repeat (2) begin
            #1;
            check("add_fwd", ALUResData, 32'h42);
            check("add_req", {31'd0, dmem.dmem_req}, 32'd0);
            tick();
            check("add_hold", W_ALURes, 32'h100);
        end
        EN = 1'b1;
        tick();
        check("add_walu", W_ALURes, 32'h42);
        check("add_wrw", {31'd0, W_RegWrite}, 32'd1);
        check("add_wnum", {27'd0, W_DR_num}, 32'd7);
        check("add_wpc", W_PC_plus_4, 32'h46);

        // LB at 0x103 with three wait cycles
        drive(1'b1, 32'h103, 32'd0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd5);
        dmem.dmem_rdata = 32'h80123456;
        stall_cycles = 0;
        repeat (3) begin
            @(negedge clk);
            if (stall) stall_cycles++;
            tick();
        end
        check("lb_wrw_bubble", {31'd0, W_RegWrite}, 32'd0);
        dmem.dmem_ack = 1'b1;
        @(negedge clk);
        if (stall) stall_cycles++;
        check("lb_stall_cycles", stall_cycles, 32'd3);
        check("lb_addr", dmem.dmem_addr, 32'h100);
        check("lb_be", {28'd0, dmem.dmem_be}, 32'hF);
        tick();
        dmem.dmem_ack = 1'b0;
        check("lb_rdata", W_ReadData, 32'hFFFFFF80);
        check("lb_wrw", {31'd0, W_RegWrite}, 32'd1);
        check("lb_wnum", {27'd0, W_DR_num}, 32'd5);

        // Zero-wait loads: LHU, LH, LBU
        dmem.dmem_ack = 1'b1;
        drive(1'b1, 32'h102, 32'd0, 3'b101, 1'b1, 1'b0, 1'b1, 5'd1);
        dmem.dmem_rdata = 32'hABCD1234;
        #1 check("lhu_stall", {31'd0, stall}, 32'd0);
        tick();
        check("lhu_rdata", W_ReadData, 32'h0000ABCD);
        drive(1'b1, 32'h100, 32'd0, 3'b001, 1'b1, 1'b0, 1'b1, 5'd2);
        dmem.dmem_rdata = 32'h12348001;
        tick();
        check("lh_rdata", W_ReadData, 32'hFFFF8001);
        drive(1'b1, 32'h101, 32'd0, 3'b100, 1'b1, 1'b0, 1'b1, 5'd3);
        dmem.dmem_rdata = 32'h0000F000;
        tick();
        check("lbu_rdata", W_ReadData, 32'h000000F0);

        // Stores: SB and SH lane steering
        drive(1'b1, 32'h101, 32'h1234565A, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0);
        #1;
        check("sb_be", {28'd0, dmem.dmem_be}, 32'h2);
        check("sb_wdata", dmem.dmem_wdata, 32'h5A5A5A5A);
        tick();
        drive(1'b1, 32'h102, 32'h0000BEEF, 3'b001, 1'b0, 1'b1, 1'b0, 5'd0);
        #1;
        check("sh_be", {28'd0, dmem.dmem_be}, 32'hC);
        check("sh_wdata", dmem.dmem_wdata, 32'hBEEFBEEF);
        tick();

        // LW at a misaligned address
        drive(1'b1, 32'h102, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd9);
        dmem.dmem_rdata = 32'hCAFEF00D;
        #1;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        check("mis_req", {31'd0, dmem.dmem_req}, 32'd0);
        tick();
        check("mis_trap", {31'd0, misalign_trap}, 32'd1);
        check("mis_addr", misalign_addr, 32'h102);
        check("mis_wrw", {31'd0, W_RegWrite}, 32'd0);
        EN = 1'b0;
        tick();
        check("mis_trap_pulse", {31'd0, misalign_trap}, 32'd0);
`else
        check("lw_addr", dmem.dmem_addr, 32'h100);
        check("lw_req", {31'd0, dmem.dmem_req}, 32'd1);
        tick();
        check("lw_rdata", W_ReadData, 32'hCAFEF00D);
        check("lw_trap", {31'd0, misalign_trap}, 32'd0);
`endif

        // Read and write both set: write wins, no load data
        drive(1'b1, 32'h104, 32'h11111111, 3'b010, 1'b1, 1'b1, 1'b0, 5'd0);
        #1 check("rw_we", {31'd0, dmem.dmem_we}, 32'd1);
        tick();
        check("rw_rdata", W_ReadData, 32'd0);
        dmem.dmem_ack = 1'b0;

        // Reset asserted while waiting, late ack afterwards ignored
        drive(1'b1, 32'h200, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd4);
        tick();
        check("rst_mid_stall_before", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_req", {31'd0, dmem.dmem_req}, 32'd0);
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_walu", W_ALURes, 32'd0);
        check("rst_mid_wrdata", W_ReadData, 32'd0);
        drive(1'b0, 32'h200, 32'd0, 3'b010, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_idle", {31'd0, dmem.dmem_req}, 32'd0);
        dmem.dmem_ack = 1'b1;
        dmem.dmem_rdata = 32'h12345678;
        tick();
        dmem.dmem_ack = 1'b0;
        #1;
        check("late_ack_req", {31'd0, dmem.dmem_req}, 32'd0);
        check("late_ack_stall", {31'd0, stall}, 32'd0);
        check("late_ack_wrdata", W_ReadData, 32'd0);
        check("late_ack_wrw", {31'd0, W_RegWrite}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
